hpf_channel_sched: RTL and testbench

Time-multiplexed scheduler for the first-order high-pass filter datapath, y[n] = alpha·(y[n-1] + x[n] − x[n-1]). It arbitrates round-robin among NCH audio sample sources and keeps per-channel filter history. It runs one shared multiply datapath and returns each filtered sample tagged with its channel. It sits between the per-channel sample sources and the output mixer.

---
 rtl/hpf_channel_sched_pkg.sv | 27 ++
 rtl/hpf_channel_sched_rr_arbiter.sv | 50 +++++
 rtl/hpf_channel_sched.sv | 166 ++++++++++++++++
 tb/tb_hpf_channel_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpf_channel_sched_pkg.sv
// hpf_pkg: shared definitions for the time-multiplexed high-pass filter
// scheduler (hpf_channel_sched) and its round-robin arbiter.
//   state_t     : scheduler FSM states
//   DEFAULT_DW  : default sample width
//   ALPHA_FRAC  : fractional bits of the Q1.15 coefficient
//   sat_max/min : signed clamp limits for a DW-bit sample
package hpf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    MUL  = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam int DEFAULT_DW = 16;
  localparam int ALPHA_FRAC = 15;

  function automatic longint sat_max(input int dw);
    return (longint'(1) <<< (dw - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

endpackage

// File: rtl/hpf_channel_sched_rr_arbiter.sv
// rr_arbiter: NCH-wide round-robin arbiter.
//   clk, rst   : clock, asynchronous active-high reset
//   req        : per-channel request vector
//   advance    : strobe; the current grant was taken, move the pointer
//   grant      : one-hot grant (combinational, zero when req is zero)
//   grant_idx  : binary index of the granted channel
// The pointer holds the last granted index; the search starts just above it
// and wraps, so after reset (pointer = NCH-1) channel 0 has top priority.
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int CHW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic           advance,
  output logic [NCH-1:0] grant,
  output logic [CHW-1:0] grant_idx
);

  logic [CHW-1:0] last_q, last_d;

  always_comb begin
    logic found;
    int   idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 1; off <= NCH; off++) begin
      idx = (int'(last_q) + off) % NCH;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = CHW'(idx);
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (advance) last_d = grant_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= CHW'(NCH - 1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/hpf_channel_sched.sv
// hpf_channel_sched: round-robin, time-multiplexed first-order high-pass
// filter y[n] = alpha * (y[n-1] + x[n] - x[n-1]) over NCH channels, one
// shared multiplier, one sample in flight.
//   clk, rst    : clock, asynchronous active-high reset
//   en          : allow new grants (an in-flight sample always completes)
//   clr         : zero all channel history while IDLE (blocks that grant)
//   alpha       : unsigned Q1.15 coefficient, captured at grant
//   req_valid/req_data/req_ready : per-channel sample inputs, one-hot accept
//   out_valid/out_data/out_ch/out_ready : filtered sample output
//   busy        : FSM is not IDLE
// Build option: define HPF_SAT_EN to clamp y to the DW-bit signed range;
// otherwise y wraps to its low DW bits.
module hpf_channel_sched
  import hpf_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW  = DEFAULT_DW,
  parameter int CHW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [15:0]       alpha,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH*DW-1:0] req_data,
  output logic [NCH-1:0]    req_ready,
  output logic              out_valid,
  output logic [DW-1:0]     out_data,
  output logic [CHW-1:0]    out_ch,
  input  logic              out_ready,
  output logic              busy
);

  state_t                state_q, state_d;
  logic signed [DW-1:0]  x_q, x_d;
  logic [CHW-1:0]        ch_q, ch_d;
  logic [15:0]           alpha_q, alpha_d;
  logic signed [DW+1:0]  d_q, d_d;
  logic [DW-1:0]         out_data_q, out_data_d;
  logic [CHW-1:0]        out_ch_q, out_ch_d;
  logic signed [DW-1:0]  x_prev_q [NCH];
  logic signed [DW-1:0]  x_prev_d [NCH];
  logic signed [DW-1:0]  y_prev_q [NCH];
  logic signed [DW-1:0]  y_prev_d [NCH];

  logic [NCH-1:0]        grant;
  logic [CHW-1:0]        grant_idx;
  logic                  grant_fire;

  logic signed [DW+17:0] p_full;
  logic signed [DW+17:0] y_wide;
  logic signed [DW-1:0]  y_fin;

  rr_arbiter #(.NCH(NCH), .CHW(CHW)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (grant_fire),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Signed difference times zero-extended alpha; the shift floors toward -inf.
  assign p_full = (DW+18)'(d_q) * (DW+18)'($signed({1'b0, alpha_q}));
  assign y_wide = p_full >>> ALPHA_FRAC;

`ifdef HPF_SAT_EN
  always_comb begin
    if (y_wide > sat_max(DW))      y_fin = DW'(sat_max(DW));
    else if (y_wide < sat_min(DW)) y_fin = DW'(sat_min(DW));
    else                           y_fin = y_wide[DW-1:0];
  end
`else
  logic unused_y_hi;
  assign y_fin       = y_wide[DW-1:0];
  assign unused_y_hi = ^y_wide[DW+17:DW];
`endif

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    ch_d       = ch_q;
    alpha_d    = alpha_q;
    d_d        = d_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    for (int k = 0; k < NCH; k++) begin
      x_prev_d[k] = x_prev_q[k];
      y_prev_d[k] = y_prev_q[k];
    end
    req_ready  = '0;
    grant_fire = 1'b0;

    case (state_q)
      IDLE: begin
        if (clr) begin
          for (int k = 0; k < NCH; k++) begin
            x_prev_d[k] = '0;
            y_prev_d[k] = '0;
          end
        end else if (en && (|req_valid)) begin
          req_ready  = grant;
          grant_fire = 1'b1;
          x_d        = req_data[int'(grant_idx)*DW +: DW];
          ch_d       = grant_idx;
          alpha_d    = alpha;
          state_d    = READ;
        end
      end
      READ: begin
        // DW+2 bits hold the worst case of two positive and one negative term.
        d_d     = (DW+2)'(y_prev_q[ch_q]) + (DW+2)'(x_q) - (DW+2)'(x_prev_q[ch_q]);
        state_d = MUL;
      end
      MUL: begin
        out_data_d = y_fin;
        out_ch_d   = ch_q;
        state_d    = OUT;
      end
      OUT: begin
        // History commits only on the handshake so a reset in flight drops it.
        if (out_ready) begin
          x_prev_d[ch_q] = x_q;
          y_prev_d[ch_q] = out_data_q;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      ch_q       <= '0;
      alpha_q    <= '0;
      d_q        <= '0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      for (int k = 0; k < NCH; k++) begin
        x_prev_q[k] <= '0;
        y_prev_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      ch_q       <= ch_d;
      alpha_q    <= alpha_d;
      d_q        <= d_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      for (int k = 0; k < NCH; k++) begin
        x_prev_q[k] <= x_prev_d[k];
        y_prev_q[k] <= y_prev_d[k];
      end
    end
  end

  assign out_valid = (state_q == OUT);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_hpf_channel_sched.sv
module tb_hpf_channel_sched;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int CHW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              clr;
  logic [15:0]       alpha;
  logic [NCH-1:0]    req_valid;
  logic [NCH*DW-1:0] req_data;
  logic [NCH-1:0]    req_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [CHW-1:0]    out_ch;
  logic              out_ready;
  logic              busy;

  hpf_channel_sched #(.NCH(NCH), .DW(DW), .CHW(CHW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .alpha     (alpha),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   xp[NCH];
  int   yp[NCH];
  int   last_data = 0;
  int   n_out = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference filter: history is updated as soon as the sample is queued.
  function automatic int model_step(int ch, int x, int a);
    longint d, p, y;
    d = longint'(yp[ch]) + longint'(x) - longint'(xp[ch]);
    p = d * longint'(a);
    y = p >>> 15;
`ifdef HPF_SAT_EN
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
`else
    y = y & 64'hFFFF;
    if (y >= 32768) y = y - 65536;
`endif
    xp[ch] = x;
    yp[ch] = int'(y);
    return int'(y);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NCH; k++) begin
      xp[k] = 0;
      yp[k] = 0;
    end
  endtask

  task automatic push(int ch, int x, int a);
    exp_t e;
    e.ch   = ch;
    e.data = model_step(ch, x, a);
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(int ch, int x);
    req_data[ch*DW +: DW] = DW'(x);
  endtask

  task automatic wait_grant(input int ch, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (req_ready[ch]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!busy && sb.size() == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check("idle_wait", done, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_clear();
    tick();
  endtask

  task automatic run_one(int ch, int x, int a);
    bit ok;
    push(ch, x, a);
    set_data(ch, x);
    alpha         = a[15:0];
    req_valid[ch] = 1'b1;
    wait_grant(ch, ok);
    check("grant", ok, 1);
    if (ok) begin
      tick();
      req_valid[ch] = 1'b0;
      alpha         = ~alpha;   // must not affect the granted sample
      tick();
      check("lat_a2_valid", out_valid, 0);
      tick();
      check("lat_a3_valid", out_valid, 1);
      wait_idle();
    end else begin
      req_valid[ch] = 1'b0;
    end
  endtask

  // Scoreboard: pop on every output handshake.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      $display("txn ch=%0d data=%0d", out_ch, $signed(out_data));
      if (sb.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        e = sb.pop_front();
        check("out_ch", out_ch, e.ch);
        check("out_data", $signed(out_data), e.data);
      end
      last_data = $signed(out_data);
      n_out++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int  order[6];
    int  got, n, prev_cyc, cyc, n_before;
    bit  ok;
    logic [DW-1:0] hold_data;

    rst       = 1'b1;
    en        = 1'b0;
    clr       = 1'b0;
    alpha     = '0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b1;
    model_clear();
    tick();
    tick();

    // Reset state.
    check("rst_req_ready", req_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    en  = 1'b1;
    tick();

    // Basic filtering.
    run_one(0, 1000, 16'h4000);
    check("basic_first", last_data, 500);
    run_one(0, 1000, 16'h4000);
    check("basic_second", last_data, 250);
    run_one(2, -5000, 16'h7FFF);
    run_one(3, 12345, 16'hFFFF);
    run_one(2, 7000, 16'h2000);

    // en low in IDLE blocks grants.
    en = 1'b0;
    set_data(1, 4321);
    req_valid[1] = 1'b1;
    tick();
    tick();
    tick();
    check("en_low_ready", req_ready, 0);
    check("en_low_busy", busy, 0);
    en = 1'b1;
    run_one(1, 4321, 16'h5000);

    // Backpressure with a competing request pending.
    out_ready = 1'b0;
    push(1, 2000, 16'h4000);
    set_data(1, 2000);
    alpha        = 16'h4000;
    req_valid[1] = 1'b1;
    wait_grant(1, ok);
    check("bp_grant", ok, 1);
    tick();
    req_valid[1] = 1'b0;
    set_data(3, -3000);
    req_valid[3] = 1'b1;
    tick();
    tick();
    hold_data = DW'(sb[0].data);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, hold_data);
      check("bp_ch", out_ch, 1);
      check("bp_ready", req_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    run_one(3, -3000, 16'h4000);

    // Round-robin with all channels requesting.
    do_reset();
    order = '{0, 1, 2, 3, 0, 1};
    alpha = 16'h6000;
    for (int k = 0; k < NCH; k++) set_data(k, 1000 * (k + 1));
    req_valid = '1;
    n = 0;
    cyc = 0;
    prev_cyc = 0;
    for (int i = 0; i < 60 && n < 6; i++) begin
      #1;
      if (req_ready != 0) begin
        got = 0;
        for (int k = 0; k < NCH; k++) if (req_ready[k]) got = k;
        check("rr_order", got, order[n]);
        if (n > 0) check("rr_spacing", cyc - prev_cyc, 4);
        prev_cyc = cyc;
        push(order[n], 1000 * (order[n] + 1), 16'h6000);
        n++;
      end
      tick();
      cyc++;
    end
    req_valid = '0;
    check("rr_count", n, 6);
    wait_idle();

    // Saturation / wrap on zero history, then the written-back value.
    do_reset();
    run_one(0, 30000, 16'hC000);
`ifdef HPF_SAT_EN
    check("sat_out", last_data, 32767);
`else
    check("sat_out", last_data, -20536);
`endif
    run_one(0, 30000, 16'h4000);

    // Reset during MUL drops the sample and clears history.
    n_before = n_out;
    set_data(1, 9000);
    alpha        = 16'h4000;
    req_valid[1] = 1'b1;
    wait_grant(1, ok);
    check("mr_grant", ok, 1);
    tick();
    req_valid[1] = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("mr_busy", busy, 0);
    check("mr_valid", out_valid, 0);
    tick();
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 6; i++) tick();
    check("mr_no_output", n_out, n_before);
    run_one(0, 1000, 16'h4000);
    check("mr_history_cleared", last_data, 500);

    // clr raised in READ, held into IDLE, with channel 1 pending.
    push(0, 2000, 16'h4000);
    set_data(0, 2000);
    alpha        = 16'h4000;
    req_valid[0] = 1'b1;
    wait_grant(0, ok);
    check("clr_grant0", ok, 1);
    tick();
    req_valid[0] = 1'b0;
    clr          = 1'b1;
    set_data(1, 3000);
    req_valid[1] = 1'b1;
    tick();
    tick();
    tick();
    check("clr_idle_busy", busy, 0);
    check("clr_idle_ready", req_ready, 0);
    model_clear();
    tick();
    clr = 1'b0;
    #1;
    check("clr_next_ready", req_ready, 4'b0010);
    push(1, 3000, 16'h4000);
    tick();
    req_valid[1] = 1'b0;
    wait_idle();
    check("clr_ch1_out", last_data, 1500);
    run_one(0, 1000, 16'h4000);
    check("clr_ch0_out", last_data, 500);

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
